serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple slice and a registered carry between cycles.
- Valid/ready handshakes on input and output allow it to sit between streaming datapath stages where a full-width single-cycle adder is too large.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH exactly; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used only when sub=0.
- sub  input  1  mode: 0 computes a+b+cin; 1 computes a-b, i.e. a+~b+1, and ignores cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; digit counter, carry, operand and result registers cleared.
  - out_valid=0, sum=0, cout=0, overflow=0.
  - in_ready=0 while rst is high.
- in_ready = (state==IDLE) & ~rst.
- out_valid = (state==DONE).
- NDIG = WIDTH/DIGIT.
- IDLE:
  - On in_valid & in_ready, latch a and the effective b (b when sub=0, ~b when sub=1).
  - Set carry = sub ? 1 : cin, cnt = 0, and go to BUSY.
  - Otherwise stay in IDLE; a, b, cin and sub are don't-care.
- BUSY, one digit per cycle:
  - Slice = bits [cnt*DIGIT +: DIGIT] of the latched operands, added with the carry register.
  - Write the slice result into the same bits of the result register and update the carry.
  - When cnt==NDIG-1:
    - Capture the carry into the MSB of the final digit (for overflow).
    - Set cout = final carry.
    - Go to DONE.
  - Otherwise cnt = cnt+1.
- Latency: out_valid rises exactly NDIG clocks after the accepting edge (4 for the defaults; 16 for DIGIT=1).
- Input changes during BUSY/DONE have no effect; operands are latched at accept.
- DONE:
  - sum, cout and overflow are stable and held for as long as out_ready=0.
  - On out_valid & out_ready, go to IDLE; in_ready rises the next cycle.
  - Throughput is therefore one operation per NDIG+2 cycles at best.
  - sum/cout/overflow keep their last value in IDLE until the next DONE; only out_valid qualifies them.
- The internal slice adder is DIGIT chained full-adder cells: sum_i = a^b^c, c_next = (a&b) | ((a^b)&c).
- No simultaneous accept and result in the same cycle; in_ready and out_valid are mutually exclusive.
- rst asserted mid-BUSY or mid-DONE aborts the operation immediately. No result is produced, and the block returns to IDLE with in_ready=1 on the first edge after rst deasserts.
- DIGIT==WIDTH is legal: NDIG=1, single BUSY cycle.

Test Plan:
- Defaults, a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, overflow=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> sum stable, out_valid=1, in_ready=0. Release -> IDLE next cycle, new op accepted.
- Assert rst during the 2nd BUSY cycle -> out_valid never rises, outputs 0. After release, a=0x0001 + b=0x0001 -> sum=0x0002.
- Rebuild with WIDTH=8, DIGIT=1: a=0xAA, b=0x55, cin=1 -> latency 8, sum=0x00, cout=1, overflow=0.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple slice,
// with a registered carry between digits and valid/ready on both sides.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       base;
    logic [DIGIT-1:0]  sl_a, sl_b, sl_s;
    logic [DIGIT:0]    ch;

    // Ripple slice of DIGIT full-adder cells fed by the registered carry.
    always_comb begin
        base = 32'(cnt_q) * DIGIT;
        sl_a = DIGIT'(a_q >> base);
        sl_b = DIGIT'(b_q >> base);
        sl_s = '0;
        ch   = '0;
        ch[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            sl_s[i]   = sl_a[i] ^ sl_b[i] ^ ch[i];
            ch[i+1]   = (sl_a[i] & sl_b[i]) | ((sl_a[i] ^ sl_b[i]) & ch[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = (acc_q & ~({{(WIDTH-DIGIT){1'b0}}, {DIGIT{1'b1}}} << base))
                        | (WIDTH'(sl_s) << base);
                carry_d = ch[DIGIT];
                if (cnt_q == CW'(NDIG - 1)) begin
                    // Outputs only move here so they hold through DONE and the following IDLE.
                    sum_d   = acc_d;
                    cout_d  = ch[DIGIT];
                    ovf_d   = ch[DIGIT] ^ ch[DIGIT-1];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: 16/4 instance with random traffic and
// backpressure, plus an 8/1 instance for the bit-serial corner.
module tb_serial_adder;
    localparam int W = 16, D = 4, N = W / D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 0, out_ready = 1, cin = 0, sub = 0;
    logic [W-1:0]  a = 0, b = 0;
    logic          in_ready, out_valid, cout, overflow;
    logic [W-1:0]  sum;

    logic          in_valid2 = 0, cin2 = 0, sub2 = 0;
    logic [7:0]    a2 = 0, b2 = 0;
    logic          in_ready2, out_valid2, cout2, overflow2;
    logic [7:0]    sum2;

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow));

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(1'b1), .sum(sum2), .cout(cout2), .overflow(overflow2));

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        longint m, av, bv, full, s, co, sa, sbb, ss;
        m    = (longint'(1) << w) - 1;
        av   = longint'(x) & m;
        bv   = longint'(sb ? ~y : y) & m;
        full = av + bv + (sb ? 1 : longint'(ci));
        s    = full & m;
        co   = (full >> w) & 1;
        sa   = (av >> (w - 1)) & 1;
        sbb  = (bv >> (w - 1)) & 1;
        ss   = (s >> (w - 1)) & 1;
        return {(sa == sbb) && (ss != sa), co[0], 16'(s)};
    endfunction

    typedef struct { logic [15:0] s; logic co; logic ov; int acc; } exp_t;
    exp_t q[$];

    int   rise = 0;
    logic prev_ov = 0;
    always @(negedge clk) begin
        exp_t e;
        if (in_ready && out_valid) chk("ready_valid_exclusive", 1, 0);
        if (out_valid && !prev_ov) rise = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.co));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("latency", rise - e.acc, N);
            end
        end
    end

    bit bp_en = 0;
    always @(posedge clk) if (bp_en) begin
        #2 out_ready = ($urandom_range(0, 3) != 0);
    end

    logic [17:0] last_exp;

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
        exp_t e;
        int k;
        @(negedge clk);
        for (k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        if (!in_ready) chk("accept_timeout", 0, 1);
        last_exp = model(W, x, y, ci, sb);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1;
        @(posedge clk);
        #1;
        e.s = last_exp[15:0]; e.co = last_exp[16]; e.ov = last_exp[17]; e.acc = cyc;
        q.push_back(e);
        in_valid = 0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int k, acc;
        logic [17:0] e8;
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout_ovf", {cout, overflow}, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        #1 chk("in_ready_after_rst", 32'(in_ready), 1);

        issue(16'h1234, 16'h4321, 0, 0);
        issue(16'hFFFF, 16'h0001, 0, 0);
        issue(16'h7FFF, 16'h0000, 1, 0);
        issue(16'h0005, 16'h0007, 1, 1);
        issue(16'h8000, 16'h0001, 0, 1);
        drain();

        bp_en = 1;
        for (int i = 0; i < 40; i++)
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();
        @(negedge clk);
        bp_en = 0;
        out_ready = 0;

        // Hold in DONE with noisy inputs.
        issue(16'hA5A5, 16'h1357, 1, 0);
        for (k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_sum", 32'(sum), 32'(last_exp[15:0]));
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
        end
        in_valid = 0;
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 chk("in_ready_after_release", 32'(in_ready), 1);
        drain();
        issue(16'h0F0F, 16'h00F1, 0, 0);
        drain();

        // Abort during the second BUSY cycle.
        issue(16'h1234, 16'h1111, 0, 0);
        @(posedge clk);
        #1 rst = 1;
        void'(q.pop_back());
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_cout_ovf", {cout, overflow}, 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 0);
        end
        chk("abort_idle_ready", 32'(in_ready), 1);
        issue(16'h0001, 16'h0001, 0, 0);
        drain();

        // Bit-serial instance.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            for (k = 0; k < 100 && !in_ready2; k++) @(negedge clk);
            if (t == 0) begin a2 = 8'hAA; b2 = 8'h55; cin2 = 1; sub2 = 0; end
            else begin a2 = 8'h10; b2 = 8'h20; cin2 = 0; sub2 = 1; end
            e8 = model(8, {8'h00, a2}, {8'h00, b2}, cin2, sub2);
            in_valid2 = 1;
            @(posedge clk);
            #1 in_valid2 = 0;
            acc = cyc;
            for (k = 0; k < 100 && !out_valid2; k++) @(negedge clk);
            chk("w8_latency", cyc - acc, 8);
            chk("w8_sum", 32'(sum2), 32'(e8[7:0]));
            chk("w8_cout", 32'(cout2), 32'(e8[16]));
            chk("w8_overflow", 32'(overflow2), 32'(e8[17]));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
